// File: rtl/byte_mem_reader.sv
// byte_mem_reader
//
// Read-side controller for a flattened byte storage array. On a start request
// it streams rd_len bytes beginning at rd_addr over a valid/ready handshake,
// wrapping the address modulo DEPTH. Each byte is sampled from mem_bus in a
// LOAD cycle, then presented until accepted, so there is one bubble per byte.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   mem_bus    in   DEPTH*8 flattened storage, byte i at [8*i+7:8*i]
//   rd_start   in   burst request, sampled only while idle
//   rd_addr    in   first byte index of the burst
//   rd_len     in   number of bytes to emit (0 gives a bare rd_done)
//   rd_busy    out  high whenever a burst is in progress (not idle)
//   out_data   out  current byte, frozen while out_valid is high
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts out_data
//   rd_done    out  one-cycle pulse after the final transfer
//
// All outputs come straight from flops.

module byte_mem_reader #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned LEN_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DEPTH*8-1:0]   mem_bus,
    input  logic                 rd_start,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [LEN_W-1:0]     rd_len,
    output logic                 rd_busy,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 rd_done
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StPresent = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                rd_done_q, rd_done_d;
    logic                rd_busy_q, rd_busy_d;

    logic [7:0]          cur_byte;
    logic [LEN_W-1:0]    len_one;

    // Byte currently addressed by the read pointer.
    assign cur_byte = mem_bus[ptr_q*8 +: 8];
    assign len_one  = LEN_W'(1);

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (rd_start) begin
                    if (rd_len != '0) begin
                        ptr_d       = rd_addr;
                        remaining_d = rd_len;
                        state_d     = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StLoad: begin
                // Sample the cell now; later mem_bus changes do not reach out_data.
                out_data_d  = cur_byte;
                out_valid_d = 1'b1;
                state_d     = StPresent;
            end

            StPresent: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - len_one;
                    // Pointer width equals log2(DEPTH), so overflow is the wrap.
                    ptr_d       = ptr_q + 1'b1;
                    state_d     = (remaining_q == len_one) ? StDone : StLoad;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered status flags are derived from the state being entered.
        rd_done_d = (state_d == StDone);
        rd_busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rd_done_q   <= rd_done_d;
            rd_busy_q   <= rd_busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign rd_done   = rd_done_q;
    assign rd_busy   = rd_busy_q;

endmodule

// File: tb/tb_byte_mem_reader.sv
// Directed bench for byte_mem_reader with hand-computed expected bytes.

module tb_byte_mem_reader;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned LEN_W  = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [DEPTH*8-1:0] mem_bus;
    logic               rd_start;
    logic [ADDR_W-1:0]  rd_addr;
    logic [LEN_W-1:0]   rd_len;
    logic               rd_busy;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;
    logic               rd_done;

    int n_checks = 0;
    int n_pass   = 0;

    byte_mem_reader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_bus   (mem_bus),
        .rd_start  (rd_start),
        .rd_addr   (rd_addr),
        .rd_len    (rd_len),
        .rd_busy   (rd_busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_done   (rd_done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        rd_start = 1'b1;
        rd_addr  = a;
        rd_len   = l;
        tick();
        rd_start = 1'b0;
    endtask

    // Bounded wait for out_valid.
    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    endtask

    // Expect one byte, stall for 'stall' cycles checking it is held, then accept.
    task automatic take(input string tag, input logic [7:0] exp, input int stall);
        wait_valid(tag);
        chk({tag, "_data"}, out_data, exp);
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_hold_v"}, {7'd0, out_valid}, 8'd1);
            chk({tag, "_hold_d"}, out_data, exp);
        end
        out_ready = 1'b1;
        tick();
        chk({tag, "_xfer_v"}, {7'd0, out_valid}, 8'd0);
        out_ready = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, {7'd0, rd_done}, 8'd1);
        chk({tag, "_busy_d"}, {7'd0, rd_busy}, 8'd1);
        tick();
        chk({tag, "_done_off"}, {7'd0, rd_done}, 8'd0);
        chk({tag, "_idle"}, {7'd0, rd_busy}, 8'd0);
    endtask

    initial begin
        reset     = 1'b1;
        mem_bus   = 64'h0706050403020100;
        rd_start  = 1'b0;
        rd_addr   = '0;
        rd_len    = '0;
        out_ready = 1'b0;

        // Reset then idle.
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", {7'd0, out_valid}, 8'd0);
            chk("rst_busy", {7'd0, rd_busy}, 8'd0);
            chk("rst_done", {7'd0, rd_done}, 8'd0);
            chk("rst_data", out_data, 8'h00);
            tick();
        end

        // Basic burst with explicit latency check: valid one edge after LOAD.
        start(3'd2, 4'd3);
        chk("b_load_busy", {7'd0, rd_busy}, 8'd1);
        chk("b_load_valid", {7'd0, out_valid}, 8'd0);
        tick();
        chk("b_lat_valid", {7'd0, out_valid}, 8'd1);
        take("b0", 8'h02, 0);
        take("b1", 8'h03, 0);
        take("b2", 8'h04, 0);
        expect_done("b");

        // Wrap and backpressure.
        start(3'd6, 4'd4);
        take("w0", 8'h06, 0);
        take("w1", 8'h07, 5);
        take("w2", 8'h00, 0);
        take("w3", 8'h01, 0);
        expect_done("w");

        // Stability while presented, resample on revisit.
        start(3'd3, 4'd10);
        wait_valid("s0");
        chk("s0_data", out_data, 8'h03);
        mem_bus[31:24] = 8'hAA;
        tick();
        chk("s0_frozen", out_data, 8'h03);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        take("s1", 8'h04, 0);
        take("s2", 8'h05, 0);
        take("s3", 8'h06, 0);
        take("s4", 8'h07, 0);
        take("s5", 8'h00, 0);
        take("s6", 8'h01, 0);
        take("s7", 8'h02, 0);
        take("s8", 8'hAA, 0);
        take("s9", 8'h04, 0);
        expect_done("s");
        mem_bus[31:24] = 8'h03;

        // Zero-length start: rd_done without any byte.
        start(3'd5, 4'd0);
        chk("z_valid", {7'd0, out_valid}, 8'd0);
        expect_done("z");
        chk("z_valid2", {7'd0, out_valid}, 8'd0);

        // Start pulse mid-burst is ignored.
        start(3'd1, 4'd3);
        take("i0", 8'h01, 0);
        rd_start = 1'b1;
        rd_addr  = 3'd5;
        rd_len   = 4'd7;
        tick();
        rd_start = 1'b0;
        take("i1", 8'h02, 0);
        take("i2", 8'h03, 0);
        expect_done("i");
        tick();
        chk("i_idle_busy", {7'd0, rd_busy}, 8'd0);
        chk("i_idle_valid", {7'd0, out_valid}, 8'd0);

        // Reset mid-burst.
        start(3'd4, 4'd5);
        wait_valid("r0");
        chk("r0_data", out_data, 8'h04);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_valid", {7'd0, out_valid}, 8'd0);
        chk("r_busy", {7'd0, rd_busy}, 8'd0);
        chk("r_done", {7'd0, rd_done}, 8'd0);
        chk("r_data", out_data, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r_quiet_v", {7'd0, out_valid}, 8'd0);
            chk("r_quiet_d", {7'd0, rd_done}, 8'd0);
        end
        start(3'd0, 4'd1);
        take("r1", 8'h00, 0);
        expect_done("r1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
